// File: rtl/parallel2serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : parallel2serial_if
//  Description : Producer-side bus of the parallel-to-serial shifter. Carries
//                the load strobe and parallel word into the shifter, and the
//                serial bit plus busy/last pacing status back out.
//  Revision    : 1.0  initial release
// ============================================================================
interface parallel2serial_if #(
  parameter int WIDTH = 8
);
  logic             en;        // load strobe
  logic [WIDTH-1:0] data_in;   // parallel word, sampled on an accepted load
  logic             data_out;  // registered serial bit stream
  logic             busy;      // frame in flight
  logic             last;      // data_out carries the final bit of the frame

  // Producer / link side: drives loads, observes the stream and status.
  modport master (
    output en,
    output data_in,
    input  data_out,
    input  busy,
    input  last
  );

  // Shifter side.
  modport slave (
    input  en,
    input  data_in,
    output data_out,
    output busy,
    output last
  );
endinterface
`default_nettype wire

// File: rtl/parallel2serial.sv
`default_nettype none
// ============================================================================
//  Module      : parallel2serial
//  Description : Parallel-in, serial-out shifter. A WIDTH-bit word captured on
//                an accepted en pulse is sent one bit per clock on a
//                registered output. busy/last let the producer pace loads,
//                including back-to-back frames with no idle gap.
//                Optional build macro P2S_PARITY_EN appends an even-parity
//                bit (XOR of the captured word) after the data bits.
//  Revision    : 1.0  initial release
// ============================================================================
module parallel2serial #(
  parameter int WIDTH      = 8,     // data word width, at least 2
  parameter int MSB_FIRST  = 0,     // 0: bit 0 first, 1: bit WIDTH-1 first
  parameter bit IDLE_LEVEL = 1'b0   // line level outside a frame
) (
  input  wire                clk,
  input  wire                nrst,  // synchronous, active-high
  parallel2serial_if.slave   bus
);

  // Frame length: data bits, plus one parity slot when parity is built in.
`ifdef P2S_PARITY_EN
  localparam int c_frame_len = WIDTH + 1;
`else
  localparam int c_frame_len = WIDTH;
`endif
  localparam int CNT_W = $clog2(c_frame_len);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(c_frame_len - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Registered state. The shift register holds the bits not yet sent,
  // with the next bit to go out sitting at the transmit end.
  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;     // index of the bit currently on data_out
  logic             r_dout;
  logic             r_last;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_sreg_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_dout_next;
  logic             w_last_next;

  // Bit-order dependent taps: first bit and remainder on load, next bit and
  // remainder on each shift.
  logic             w_load_first;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_shift_bit;
  logic [WIDTH-1:0] w_shift_rest;

  // Parity slot selection; constant low when parity is not built.
  logic             w_parity_slot;
  logic             w_parity_bit;
  logic             w_load_ok;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load_first = bus.data_in[WIDTH-1];
      assign w_load_rest  = {bus.data_in[WIDTH-2:0], 1'b0};
      assign w_shift_bit  = r_sreg[WIDTH-1];
      assign w_shift_rest = {r_sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_load_first = bus.data_in[0];
      assign w_load_rest  = {1'b0, bus.data_in[WIDTH-1:1]};
      assign w_shift_bit  = r_sreg[0];
      assign w_shift_rest = {1'b0, r_sreg[WIDTH-1:1]};
    end
  endgenerate

`ifdef P2S_PARITY_EN
  logic r_parity;
  logic w_parity_next;

  // Parity of the captured word, latched at load time.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_next;
    end
  end

  // Recompute parity only on an accepted load.
  always_comb begin
    w_parity_next = r_parity;
    if (bus.en && w_load_ok) begin
      w_parity_next = ^bus.data_in;
    end
  end

  assign w_parity_slot = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_parity_bit  = r_parity;
`else
  assign w_parity_slot = 1'b0;
  assign w_parity_bit  = 1'b0;
`endif

  // A load is accepted when idle, or on the final slot of the current frame.
  assign w_load_ok = (r_state == IDLE) || r_last;

  // State register and datapath flops; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_dout  <= IDLE_LEVEL;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sreg  <= w_sreg_next;
      r_cnt   <= w_cnt_next;
      r_dout  <= w_dout_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_next = r_state;
    w_sreg_next  = r_sreg;
    w_cnt_next   = r_cnt;
    w_dout_next  = r_dout;
    w_last_next  = 1'b0;

    if (bus.en && w_load_ok) begin
      // Capture: the first bit goes straight onto the line at this edge.
      w_state_next = SHIFT;
      w_sreg_next  = w_load_rest;
      w_cnt_next   = '0;
      w_dout_next  = w_load_first;
    end else if (r_state == SHIFT) begin
      if (r_last) begin
        // Frame complete and no follow-on load: return the line to idle.
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_dout_next  = IDLE_LEVEL;
      end else begin
        w_cnt_next  = r_cnt + CNT_W'(1);
        w_last_next = (w_cnt_next == c_last_idx);
        if (w_parity_slot) begin
          w_dout_next = w_parity_bit;
        end else begin
          w_dout_next = w_shift_bit;
          w_sreg_next = w_shift_rest;
        end
      end
    end
  end

  assign bus.data_out = r_dout;
  assign bus.busy     = (r_state == SHIFT);
  assign bus.last     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_parallel2serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parallel2serial
//  Description : Directed bench for parallel2serial. Two instances, LSB-first
//                and MSB-first, share clock, reset and load stimulus; every
//                cycle of each frame is compared against hand-derived bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parallel2serial;

`ifdef P2S_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [7:0] din;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  parallel2serial_if #(.WIDTH(8)) bus_l ();
  parallel2serial_if #(.WIDTH(8)) bus_m ();

  assign bus_l.en      = en;
  assign bus_l.data_in = din;
  assign bus_m.en      = en;
  assign bus_m.data_in = din;

  parallel2serial #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_l)
  );

  parallel2serial #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout_l"}, bus_l.data_out, 1'b0);
    chk({tag, "_busy_l"}, bus_l.busy,     1'b0);
    chk({tag, "_last_l"}, bus_l.last,     1'b0);
    chk({tag, "_dout_m"}, bus_m.data_out, 1'b0);
    chk({tag, "_busy_m"}, bus_m.busy,     1'b0);
    chk({tag, "_last_m"}, bus_m.last,     1'b0);
  endtask

  // Pulse en for one edge; afterwards scramble data_in, which must not matter.
  task automatic load(input logic [7:0] w);
    en  = 1'b1;
    din = w;
    step();
    en  = 1'b0;
    din = ~w;
  endtask

  // Called in the cycle right after the load edge; walks the whole frame and
  // returns in the cycle that carries the final slot. When poke >= 0 an en
  // pulse with 0xFF is issued during that bit's cycle.
  task automatic expect_frame(input logic [7:0] w, input int poke, input string tag);
    logic [7:0] wv;
    logic       el;
    logic       em;
    wv = w;
    for (int k = 0; k < FL; k++) begin
      if (k < 8) begin
        el = wv[k];
        em = wv[7-k];
      end else begin
        el = ^wv;
        em = ^wv;
      end
      chk($sformatf("%s_b%0d_dout_l", tag, k), bus_l.data_out, el);
      chk($sformatf("%s_b%0d_dout_m", tag, k), bus_m.data_out, em);
      chk($sformatf("%s_b%0d_busy_l", tag, k), bus_l.busy, 1'b1);
      chk($sformatf("%s_b%0d_busy_m", tag, k), bus_m.busy, 1'b1);
      chk($sformatf("%s_b%0d_last_l", tag, k), bus_l.last, (k == FL - 1));
      chk($sformatf("%s_b%0d_last_m", tag, k), bus_m.last, (k == FL - 1));
      if (k != FL - 1) begin
        if (k == poke) begin
          en  = 1'b1;
          din = 8'hFF;
        end
        step();
        en = 1'b0;
      end
    end
  endtask

  initial begin
    nrst = 1'b1;
    en   = 1'b0;
    din  = 8'h00;

    // Reset held with en toggling: nothing may load.
    for (int i = 0; i < 5; i++) begin
      en  = (i % 2 == 0);
      din = 8'hFF;
      step();
      chk_idle($sformatf("rst%0d", i));
    end
    nrst = 1'b0;
    en   = 1'b0;
    step();
    chk_idle("post_rst");

    // Single frame 0xA5, then back to idle.
    load(8'hA5);
    expect_frame(8'hA5, -1, "f_a5");
    step();
    chk_idle("f_a5_end");

    // Idle gap with data_in wandering.
    for (int i = 0; i < 10; i++) begin
      din = 8'($urandom);
      step();
    end
    chk_idle("gap");

    // Second frame 0x36.
    load(8'h36);
    expect_frame(8'h36, -1, "f_36");
    step();
    chk_idle("f_36_end");

    // Ignored load at bit 3, then back-to-back load on the last slot.
    load(8'hA5);
    expect_frame(8'hA5, 3, "poke");
    en  = 1'b1;
    din = 8'h36;
    step();
    en  = 1'b0;
    din = 8'h00;
    expect_frame(8'h36, -1, "b2b");
    step();
    chk_idle("b2b_end");

    // Reset asserted while bit 4 is on the line aborts the frame.
    load(8'hA5);
    for (int i = 0; i < 4; i++) step();
    chk("mid_b4_dout_l", bus_l.data_out, 1'b0);
    chk("mid_b4_dout_m", bus_m.data_out, 1'b0);
    nrst = 1'b1;
    step();
    chk_idle("mid_rst");
    nrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle($sformatf("mid_rel%0d", i));
    end

    // Word with odd parity.
    load(8'h07);
    expect_frame(8'h07, -1, "f_07");
    step();
    chk_idle("f_07_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
